ttl_latch_write_sched: RTL and testbench

//  Shares one positive-edge quad D latch (74175-style synchronous model) between N_REQ requesters.

---
 rtl/ttl_latch_write_sched.sv | 158 +++++++++++++++
 tb/tb_ttl_latch_write_sched.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/ttl_latch_write_sched.sv
// Write scheduler sharing one 74175-style quad latch between N_REQ requesters.
// Define LATCH_SCHED_FIXED_PRIO_EN for fixed lowest-index-wins priority (default: round-robin).
module ttl_latch_write_sched #(
    parameter int N_REQ      = 4,
    parameter int CEN_LOW    = 2,
    parameter int CEN_HIGH   = 2,
    parameter int CLR_CYCLES = 4
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [N_REQ-1:0]   req,
    input  logic [4*N_REQ-1:0] req_data,
    input  logic               clr_req,
    output logic [N_REQ-1:0]   ack,
    output logic               busy,
    output logic [3:0]         latch_d,
    output logic               latch_cen,
    output logic               latch_clr_n
);

    localparam int MAX_A   = (CEN_LOW > CEN_HIGH) ? CEN_LOW : CEN_HIGH;
    localparam int MAX_CNT = (MAX_A > CLR_CYCLES) ? MAX_A : CLR_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT) + 1;
    localparam int IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [2:0] {CLEAR, IDLE, SETUP, STROBE, ACK} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [IDX_W-1:0]   cur;
    logic [IDX_W-1:0]   win;
    logic [3:0]         wdata;
    logic [N_REQ-1:0]   cur_onehot;
    logic               clr_pend;

`ifdef LATCH_SCHED_FIXED_PRIO_EN
    // Descending scan so the lowest requesting index is the final assignment.
    always_comb begin
        win = '0;
        for (int i = N_REQ - 1; i >= 0; i--)
            if (req[i]) win = IDX_W'(i);
    end
`else
    logic [IDX_W-1:0] ptr;

    // Scan the search order backwards so the first hit after ptr wins.
    always_comb begin
        int idx;
        win = '0;
        idx = 0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (req[IDX_W'(idx)]) win = IDX_W'(idx);
        end
    end
`endif

    always_comb begin
        wdata = '0;
        for (int i = 0; i < N_REQ; i++)
            if (IDX_W'(i) == win) wdata = req_data[4*i +: 4];
    end

    always_comb begin
        cur_onehot = '0;
        cur_onehot[cur] = 1'b1;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state       <= CLEAR;
            cnt         <= '0;
            cur         <= '0;
`ifndef LATCH_SCHED_FIXED_PRIO_EN
            ptr         <= IDX_W'(N_REQ - 1);
`endif
            clr_pend    <= 1'b0;
            ack         <= '0;
            busy        <= 1'b1;
            latch_d     <= '0;
            latch_cen   <= 1'b1;
            latch_clr_n <= 1'b0;
        end else begin
            ack <= '0;
            case (state)
                CLEAR: begin
                    if (clr_req) clr_pend <= 1'b1;
                    if (cnt == CNT_W'(CLR_CYCLES - 1)) begin
                        state       <= IDLE;
                        cnt         <= '0;
                        busy        <= 1'b0;
                        latch_clr_n <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (clr_req || clr_pend) begin
                        state       <= CLEAR;
                        clr_pend    <= 1'b0;
                        cnt         <= '0;
                        busy        <= 1'b1;
                        latch_clr_n <= 1'b0;
                    end else if (|req) begin
                        state     <= SETUP;
                        cur       <= win;
`ifndef LATCH_SCHED_FIXED_PRIO_EN
                        ptr       <= win;
`endif
                        latch_d   <= wdata;
                        latch_cen <= 1'b0;
                        cnt       <= '0;
                        busy      <= 1'b1;
                    end
                end
                SETUP: begin
                    if (clr_req) clr_pend <= 1'b1;
                    if (cnt == CNT_W'(CEN_LOW - 1)) begin
                        state     <= STROBE;
                        latch_cen <= 1'b1;   // rising edge: latch loads latch_d
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STROBE: begin
                    if (clr_req) clr_pend <= 1'b1;
                    if (cnt == CNT_W'(CEN_HIGH - 1)) begin
                        state <= ACK;
                        ack   <= cur_onehot;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ACK: begin
                    if (clr_req || clr_pend) begin
                        state       <= CLEAR;
                        clr_pend    <= 1'b0;
                        cnt         <= '0;
                        latch_clr_n <= 1'b0;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state       <= CLEAR;
                    cnt         <= '0;
                    busy        <= 1'b1;
                    latch_cen   <= 1'b1;
                    latch_clr_n <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ttl_latch_write_sched.sv
// Directed bench for ttl_latch_write_sched with a behavioural 74175 latch on its outputs.
module tb_ttl_latch_write_sched;

    logic        Clk;
    logic        Reset;
    logic [3:0]  req;
    logic [15:0] req_data;
    logic        clr_req;
    logic [3:0]  ack;
    logic        busy;
    logic [3:0]  latch_d;
    logic        latch_cen;
    logic        latch_clr_n;

    int checks   = 0;
    int failures = 0;

    logic [3:0] latch_q  = 4'h3;
    logic       last_cen = 1'b1;

    ttl_latch_write_sched #(
        .N_REQ(4), .CEN_LOW(2), .CEN_HIGH(2), .CLR_CYCLES(4)
    ) dut (
        .Clk(Clk), .Reset(Reset), .req(req), .req_data(req_data), .clr_req(clr_req),
        .ack(ack), .busy(busy), .latch_d(latch_d), .latch_cen(latch_cen),
        .latch_clr_n(latch_clr_n)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Synchronous quad latch: clear dominates, load on Cen low->high.
    always @(posedge Clk) begin
        if (!latch_clr_n) latch_q <= 4'h0;
        else if (latch_cen && !last_cen) latch_q <= latch_d;
        last_cen <= latch_cen;
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    int exp_g[5];

    initial begin
`ifdef LATCH_SCHED_FIXED_PRIO_EN
        exp_g = '{0, 0, 0, 0, 0};
`else
        exp_g = '{0, 1, 2, 3, 0};
`endif
        Reset = 1'b1; req = '0; req_data = '0; clr_req = 1'b0;
        tick(); tick();
        chk("rst_ack",   32'(ack), 32'h0);
        chk("rst_busy",  32'(busy), 32'h1);
        chk("rst_d",     32'(latch_d), 32'h0);
        chk("rst_cen",   32'(latch_cen), 32'h1);
        chk("rst_clr_n", 32'(latch_clr_n), 32'h0);

        // 1: clear sequence after reset release
        Reset = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("t1_clr_low", 32'(latch_clr_n), 32'h0);
            chk("t1_busy_hi", 32'(busy), 32'h1);
            chk("t1_cen",     32'(latch_cen), 32'h1);
        end
        tick();
        chk("t1_clr_high", 32'(latch_clr_n), 32'h1);
        chk("t1_busy_low", 32'(busy), 32'h0);
        chk("t1_cen_end",  32'(latch_cen), 32'h1);
        chk("t1_q_clear",  32'(latch_q), 32'h0);

        // 3: all requesters held; round-robin from pointer at N_REQ-1
        req = 4'b1111; req_data = 16'h4321;
        for (int g = 0; g < 5; g++) begin
            repeat (g == 0 ? 5 : 6) tick();
            chk("t3_ack",   32'(ack), 32'(4'b0001 << exp_g[g]));
            chk("t3_d",     32'(latch_d), 32'(exp_g[g] + 1));
            chk("t3_cen",   32'(latch_cen), 32'h1);
        end
        req = 4'b0000;
        tick();
        chk("t3_idle", 32'(busy), 32'h0);

        // 2: single write, data changes after grant are ignored
        req = 4'b0100; req_data = 16'h1A23;
        tick();
        chk("t2_c1_cen", 32'(latch_cen), 32'h0);
        chk("t2_c1_d",   32'(latch_d), 32'hA);
        chk("t2_c1_busy", 32'(busy), 32'h1);
        req_data = 16'h1523;
        tick();
        chk("t2_c2_cen", 32'(latch_cen), 32'h0);
        tick();
        chk("t2_c3_cen", 32'(latch_cen), 32'h1);
        chk("t2_c3_ack", 32'(ack), 32'h0);
        tick();
        chk("t2_c4_q",   32'(latch_q), 32'hA);
        chk("t2_c4_ack", 32'(ack), 32'h0);
        tick();
        chk("t2_c5_ack", 32'(ack), 32'b0100);
        req = 4'b0000;
        tick();
        chk("t2_c6_ack",  32'(ack), 32'h0);
        chk("t2_c6_busy", 32'(busy), 32'h0);
        chk("t2_c6_q",    32'(latch_q), 32'hA);

        // 4: clear request during STROBE waits for the write to finish
        req = 4'b0010; req_data = 16'h0050;
        tick(); tick(); tick();
        chk("t4_c3_cen", 32'(latch_cen), 32'h1);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        chk("t4_c4_q",   32'(latch_q), 32'h5);
        tick();
        chk("t4_c5_ack", 32'(ack), 32'b0010);
        req = 4'b0000;
        for (int i = 6; i <= 9; i++) begin
            tick();
            chk("t4_clr_low", 32'(latch_clr_n), 32'h0);
            chk("t4_ack_0",   32'(ack), 32'h0);
        end
        tick();
        chk("t4_clr_high", 32'(latch_clr_n), 32'h1);
        chk("t4_busy_low", 32'(busy), 32'h0);
        chk("t4_q_clear",  32'(latch_q), 32'h0);

        // 5: clear and write in the same IDLE cycle -> clear first
        req = 4'b0010; req_data = 16'h00C0; clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        chk("t5_c1_clr", 32'(latch_clr_n), 32'h0);
        chk("t5_c1_cen", 32'(latch_cen), 32'h1);
        tick(); tick(); tick();
        chk("t5_c4_clr", 32'(latch_clr_n), 32'h0);
        tick();
        chk("t5_c5_clr", 32'(latch_clr_n), 32'h1);
        tick();
        chk("t5_c6_cen", 32'(latch_cen), 32'h0);
        chk("t5_c6_d",   32'(latch_d), 32'hC);
        tick(); tick(); tick();
        chk("t5_c9_ack", 32'(ack), 32'h0);
        tick();
        chk("t5_c10_ack", 32'(ack), 32'b0010);
        req = 4'b0000;
        tick();
        chk("t5_q", 32'(latch_q), 32'hC);

        // 6: asynchronous reset during SETUP aborts without ack
        req = 4'b0001; req_data = 16'h0007;
        tick();
        chk("t6_c1_cen", 32'(latch_cen), 32'h0);
        #2 Reset = 1'b1;
        #1;
        chk("t6_rst_busy",  32'(busy), 32'h1);
        chk("t6_rst_cen",   32'(latch_cen), 32'h1);
        chk("t6_rst_clr_n", 32'(latch_clr_n), 32'h0);
        chk("t6_rst_d",     32'(latch_d), 32'h0);
        chk("t6_rst_ack",   32'(ack), 32'h0);
        chk("t6_q_kept",    32'(latch_q), 32'hC);
        tick(); tick();
        Reset = 1'b0; req = 4'b0000;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("t6_no_ack", 32'(ack), 32'h0);
        end
        chk("t6_idle", 32'(busy), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
